// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (m0) and a
// loader/debug port (m1); one checked memory access per grant, registered response to the owner.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  input  logic [2:0]        m0_req_funct3,
  output logic              m0_rsp_valid,
  output logic              m0_rsp_err,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  input  logic [2:0]        m1_req_funct3,
  output logic              m1_rsp_valid,
  output logic              m1_rsp_err,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  output logic [2:0]        funct3,
  input  logic [DATA_W-1:0] read_data
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e            state_q;
  logic              last_grant_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        funct3_q;
  logic [1:0]        rsp_valid_q;
  logic [1:0]        rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q [2];

  logic              any_valid;
  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_funct3;
  logic              legal;
  logic              busy_ok;

  function automatic logic legal_f(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic f3_ok;
    logic aligned;
    if (we) f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    f3_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
    case (f3[1:0])
      2'b01:   aligned = ~a[0];
      2'b10:   aligned = (a == 2'b00);
      default: aligned = 1'b1;
    endcase
    return f3_ok && aligned;
  endfunction

  // On a tie the port that did not win last time is selected.
  always_comb begin
    any_valid = m0_req_valid | m1_req_valid;
    if (m0_req_valid && m1_req_valid) sel = ~last_grant_q;
    else                              sel = m1_req_valid;
    sel_we     = sel ? m1_req_we     : m0_req_we;
    sel_addr   = sel ? m1_req_addr   : m0_req_addr;
    sel_wdata  = sel ? m1_req_wdata  : m0_req_wdata;
    sel_funct3 = sel ? m1_req_funct3 : m0_req_funct3;
  end

  assign m0_req_ready = rst && (state_q == IDLE) && any_valid && !sel;
  assign m1_req_ready = rst && (state_q == IDLE) && any_valid &&  sel;

  assign legal      = legal_f(we_q, funct3_q, addr_q[1:0]);
  assign busy_ok    = (state_q == BUSY) && legal;
  assign MemRead    = busy_ok && !we_q;
  assign MemWrite   = busy_ok &&  we_q;
  assign addr       = busy_ok ? addr_q   : '0;
  assign write_data = busy_ok ? wdata_q  : '0;
  assign funct3     = busy_ok ? funct3_q : '0;

  assign m0_rsp_valid = rsp_valid_q[0];
  assign m1_rsp_valid = rsp_valid_q[1];
  assign m0_rsp_err   = rsp_err_q[0];
  assign m1_rsp_err   = rsp_err_q[1];
  assign m0_rsp_rdata = rsp_rdata_q[0];
  assign m1_rsp_rdata = rsp_rdata_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      owner_q        <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      funct3_q       <= '0;
      rsp_valid_q    <= 2'b00;
      rsp_err_q      <= 2'b00;
      rsp_rdata_q[0] <= '0;
      rsp_rdata_q[1] <= '0;
    end else begin
      rsp_valid_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            we_q         <= sel_we;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            funct3_q     <= sel_funct3;
            owner_q      <= sel;
            last_grant_q <= sel;
            state_q      <= BUSY;
          end
        end
        // Load data is captured here; stores and illegal requests answer with zero.
        BUSY: begin
          state_q                <= RESP;
          rsp_valid_q[owner_q]   <= 1'b1;
          rsp_err_q[owner_q]     <= ~legal;
          rsp_rdata_q[owner_q]   <= (legal && !we_q) ? read_data : '0;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
